// File: rtl/seq_control_pkg.sv
// Shared codes for the multi-cycle sequencer:
// prefixes, sequencer opcodes, states and the EXEC dispatch helper.
package seq_control_pkg;

  localparam logic [1:0] PFX_ALU   = 2'b00;
  localparam logic [1:0] PFX_LDST  = 2'b01;
  localparam logic [1:0] PFX_JUMP  = 2'b10;
  localparam logic [1:0] PFX_NPHLT = 2'b11;

  localparam logic [4:0] OP_LOAD  = 5'b10000;
  localparam logic [4:0] OP_LOADC = 5'b10001;
  localparam logic [4:0] OP_STORE = 5'b10010;
  localparam logic [4:0] OP_JMP   = 5'b10011;
  localparam logic [4:0] OP_JMPR  = 5'b10100;
  localparam logic [4:0] OP_JC1   = 5'b10101;
  localparam logic [4:0] OP_JC2   = 5'b10110;
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b11111;
  localparam logic [4:0] OP_UNDEF = 5'b00000;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    A_WB,
    A_LOAD,
    A_STORE,
    A_JUMP,
    A_BRANCH,
    A_NEXT,
    A_HALT,
    A_ILLEGAL
  } act_t;

  // Collapses prefix + opcode into the action EXEC performs.
  function automatic act_t classify(
    input logic [1:0] pfx,
    input logic [4:0] op
  );
    act_t a;
    a = A_NEXT;
    unique case (1'b1)
      pfx == PFX_ALU: a = A_WB;
      pfx == PFX_NPHLT:
        a = (op == OP_HALT) ? A_HALT : A_NEXT;
      (pfx == PFX_LDST) || (pfx == PFX_JUMP): begin
        case (op)
          OP_LOAD:         a = A_LOAD;
          OP_LOADC:        a = A_WB;
          OP_STORE:        a = A_STORE;
          OP_JMP, OP_JMPR: a = A_JUMP;
          OP_JC1, OP_JC2:  a = A_BRANCH;
          default: begin
            if (pfx == PFX_LDST && op == OP_UNDEF)
              a = A_ILLEGAL;
            else
              a = A_NEXT;
          end
        endcase
      end
      default: a = A_NEXT;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/seq_control.sv
// Multi-cycle control sequencer: owns PC and IR, walks
// FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
module seq_control
  import seq_control_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic [15:0]       ir,
  input  logic [18:0]       dec_data,
  output logic              alu_en,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              rf_we,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  state_t state, state_nxt;
  act_t   act_q, act_dec;

  logic [ADDR_W-1:0] pc_inc, pc_nxt;
  logic retire;
  logic imem_req_d, alu_en_d, rf_we_d;
  logic dmem_req_d, dmem_we_d, halted_d;
  logic unused_dec;

  assign imem_addr  = pc;
  assign pc_inc     = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign act_dec    = classify(ir[15:14], dec_data[18:14]);
  assign unused_dec = ^dec_data[13:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:
        if (imem_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        case (act_q)
          A_WB:             state_nxt = S_WB;
          A_LOAD, A_STORE:  state_nxt = S_MEM;
          A_HALT:           state_nxt = S_HALTED;
          default:          state_nxt = S_FETCH;
        endcase
      end
      S_MEM:
        if (dmem_ack)
          state_nxt = (act_q == A_STORE) ? S_FETCH : S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    retire = 1'b0;
    unique case (1'b1)
      state == S_EXEC: begin
        retire = !(act_q inside {A_WB, A_LOAD, A_STORE});
        case (act_q)
          A_JUMP:   pc_nxt = jmp_target;
          A_BRANCH: pc_nxt = branch_taken ? jmp_target : pc_inc;
          A_NEXT, A_ILLEGAL: pc_nxt = pc_inc;
          default: ;
        endcase
      end
      state == S_MEM: begin
        if (dmem_ack && act_q == A_STORE) begin
          pc_nxt = pc_inc;
          retire = 1'b1;
        end
      end
      state == S_WB: begin
        pc_nxt = pc_inc;
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are decoded from the next state so every output is a flop.
  always_comb begin
    imem_req_d = (state_nxt == S_FETCH);
    alu_en_d   = (state_nxt == S_EXEC);
    rf_we_d    = (state_nxt == S_WB);
    dmem_req_d = (state_nxt == S_MEM);
    dmem_we_d  = (state_nxt == S_MEM) && (act_q == A_STORE);
    halted_d   = (state_nxt == S_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      ir       <= '0;
      retired  <= '0;
      act_q    <= A_NEXT;
      illegal  <= 1'b0;
      imem_req <= 1'b0;
      alu_en   <= 1'b0;
      rf_we    <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (retire)
        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      if (state == S_FETCH && imem_ack)
        ir <= imem_data;
      if (state == S_DECODE)
        act_q <= act_dec;
      if (state == S_EXEC && act_q == A_ILLEGAL)
        illegal <= 1'b1;
      imem_req <= imem_req_d;
      alu_en   <= alu_en_d;
      rf_we    <= rf_we_d;
      dmem_req <= dmem_req_d;
      dmem_we  <= dmem_we_d;
      halted   <= halted_d;
    end
  end

endmodule

// File: tb/tb_seq_control.sv
// Randomised scoreboard bench for seq_control with a
// per-instruction behavioural model and directed corner cases.
module tb_seq_control;
  import seq_control_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr, jmp_target, pc;
  logic [15:0] imem_data, ir, retired;
  logic [18:0] dec_data;
  logic        alu_en, branch_taken;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        rf_we, halted, illegal;

  always #5 clk = ~clk;

  // Stand-in for the external decoder.
  assign dec_data = {ir[13:9], ir[8:6], ir[5:3], ir[7:0]};

  seq_control #(.ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .ir(ir), .dec_data(dec_data),
    .alu_en(alu_en), .branch_taken(branch_taken),
    .jmp_target(jmp_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .rf_we(rf_we), .pc(pc),
    .halted(halted), .illegal(illegal),
    .retired(retired)
  );

  typedef struct {
    logic [15:0] w;
    logic        tk;
    logic [7:0]  tg;
    int          id;
    int          dd;
  } plan_t;

  typedef struct {
    logic [7:0] pc;
    int         rf;
    int         memc;
    logic       we;
    logic       ill;
    logic       hlt;
  } exp_t;

  plan_t      planq[$];
  exp_t       sbq[$];
  logic [7:0] mp;
  logic       ill_m;
  int         cur_dd;
  int         passed, total;
  logic       mon_en;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  nm, act, exp);
  endtask

  function automatic plan_t mk(input logic [1:0] pf,
                               input logic [4:0] op,
                               input logic tk,
                               input logic [7:0] tg,
                               input int dd);
    plan_t p;
    p.w  = {pf, op, 9'($urandom)};
    p.tk = tk;
    p.tg = tg;
    p.id = $urandom_range(0, 2);
    p.dd = dd;
    return p;
  endfunction

  function automatic plan_t rnd();
    logic [1:0] pf;
    logic [4:0] op;
    int sel;
    pf  = 2'($urandom_range(0, 3));
    sel = $urandom_range(0, 3);
    if (sel == 0)      op = 5'b00000;
    else if (sel < 3)  op = 5'(16 + $urandom_range(0, 6));
    else               op = 5'($urandom);
    if (pf == 2'b11 && op == OP_HALT) op = OP_NOP;
    return mk(pf, op, 1'($urandom), 8'($urandom),
              $urandom_range(0, 3));
  endfunction

  // Instruction-level reference: effect of one instruction.
  task automatic predict(input plan_t p, output exp_t e);
    logic [1:0] pf;
    logic [4:0] op;
    logic [7:0] nxt;
    pf = p.w[15:14];
    op = p.w[13:9];
    e.rf = 0; e.memc = 0; e.we = 1'b0; e.hlt = 1'b0;
    nxt = mp + 8'd1;
    if (pf == 2'b00) e.rf = 1;
    else if (pf == 2'b11) begin
      if (op == OP_HALT) begin e.hlt = 1'b1; nxt = mp; end
    end
    else if (op == OP_LOAD) begin
      e.memc = p.dd + 1; e.rf = 1;
    end
    else if (op == OP_LOADC) e.rf = 1;
    else if (op == OP_STORE) begin
      e.memc = p.dd + 1; e.we = 1'b1;
    end
    else if (op == OP_JMP || op == OP_JMPR) nxt = p.tg;
    else if (op == OP_JC1 || op == OP_JC2)
      nxt = p.tk ? p.tg : mp + 8'd1;
    else if (pf == 2'b01 && op == 5'b00000) ill_m = 1'b1;
    mp    = nxt;
    e.pc  = mp;
    e.ill = ill_m;
  endtask

  task automatic fetch_drv();
    plan_t p;
    exp_t  e;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (planq.size() > 0) p = planq.pop_front();
        else p = mk(2'b11, OP_NOP, 1'b0, 8'h00, 0);
        chk("imem_addr", 32'(imem_addr), 32'(mp));
        predict(p, e);
        cur_dd = p.dd;
        repeat (p.id) @(negedge clk);
        imem_data    = p.w;
        branch_taken = p.tk;
        jmp_target   = p.tg;
        imem_ack     = 1'b1;
        @(posedge clk);
        #1 imem_ack = 1'b0;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic dmem_drv();
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        repeat (cur_dd) @(negedge clk);
        dmem_ack = 1'b1;
        @(posedge clk);
        #1 dmem_ack = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    int rf_c = 0, alu_c = 0, mem_c = 0;
    logic we_s = 1'b0;
    logic [15:0] last = 16'd0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (retired != last) begin
          if (sbq.size() == 0)
            chk("retire_without_issue", 32'd1, 32'd0);
          else begin
            e = sbq.pop_front();
            chk("pc", 32'(pc), 32'(e.pc));
            chk("retired", 32'(retired), 32'(last + 16'd1));
            chk("rf_we_cycles", 32'(rf_c), 32'(e.rf));
            chk("alu_en_cycles", 32'(alu_c), 32'd1);
            chk("dmem_req_cycles", 32'(mem_c), 32'(e.memc));
            chk("dmem_we", 32'(we_s), 32'(e.we));
            chk("illegal", 32'(illegal), 32'(e.ill));
            chk("halted", 32'(halted), 32'(e.hlt));
          end
          last  = retired;
          rf_c  = 0; alu_c = 0; mem_c = 0;
          we_s  = 1'b0;
        end
        rf_c  += int'(rf_we);
        alu_c += int'(alu_en);
        mem_c += int'(dmem_req);
        we_s  |= dmem_req & dmem_we;
      end
    end
  endtask

  initial begin
    int busy;
    rst = 1'b1; imem_ack = 1'b0; imem_data = 16'h0;
    dmem_ack = 1'b0; branch_taken = 1'b0;
    jmp_target = 8'h0; mon_en = 1'b0;
    passed = 0; total = 0; cur_dd = 0;
    mp = 8'h0; ill_m = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem", 32'({dmem_req, dmem_we}), 32'd0);
    chk("rst_strobes", 32'({alu_en, rf_we}), 32'd0);
    chk("rst_flags", 32'({halted, illegal}), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);

    // ALU 0x0000 with zero-wait fetch; cycle 1 = first request.
    rst = 1'b0;
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);
    imem_data = 16'h0000; imem_ack = 1'b1;
    @(posedge clk); #1 imem_ack = 1'b0;
    @(negedge clk);
    chk("c2_alu_en", 32'(alu_en), 32'd0);
    @(negedge clk);
    chk("c3_alu_en", 32'(alu_en), 32'd1);
    @(negedge clk);
    chk("c4_rf_we", 32'({rf_we, alu_en}), 32'd2);
    @(negedge clk);
    chk("alu_pc", 32'(pc), 32'd1);
    chk("alu_retired", 32'(retired), 32'd1);
    chk("alu_refetch", 32'(imem_req), 32'd1);

    // LOAD, then reset while waiting in MEM.
    imem_data = 16'h6000; imem_ack = 1'b1;
    @(posedge clk); #1 imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("mem_req", 32'({dmem_req, dmem_we}), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_mid_pc", 32'(pc), 32'd0);
    chk("rst_mid_retired", 32'(retired), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("post_rst_fetch", 32'(imem_req), 32'd1);
    chk("post_rst_pc", 32'(pc), 32'd0);

    planq.push_back(mk(2'b01, OP_LOADC, 1'b0, 8'h00, 0));
    planq.push_back(mk(2'b01, OP_STORE, 1'b0, 8'h00, 2));
    planq.push_back(mk(2'b10, OP_JC1, 1'b1, 8'h40, 0));
    planq.push_back(mk(2'b10, OP_JC1, 1'b0, 8'h40, 0));
    planq.push_back(mk(2'b10, OP_JMP, 1'b0, 8'hFF, 0));
    planq.push_back(mk(2'b11, OP_NOP, 1'b0, 8'h00, 0));
    for (int i = 0; i < 60; i++) planq.push_back(rnd());
    planq.push_back(mk(2'b01, OP_UNDEF, 1'b0, 8'h00, 0));
    planq.push_back(mk(2'b11, OP_HALT, 1'b0, 8'h00, 0));
    mon_en = 1'b1;
    fork
      fetch_drv();
      dmem_drv();
      monitor();
    join_none

    for (int i = 0; i < 20000 && !halted; i++) @(negedge clk);
    chk("halt_reached", 32'(halted), 32'd1);
    repeat (2) @(negedge clk);
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      busy += int'(imem_req) + int'(alu_en)
            + int'(dmem_req) + int'(rf_we);
    end
    chk("halted_idle", 32'(busy), 32'd0);
    chk("halted_hold", 32'(halted), 32'd1);
    chk("illegal_sticky", 32'(illegal), 32'd1);
    chk("final_pc", 32'(pc), 32'(mp));
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
